// File: rtl/fp_conv_pkg.sv
// Shared types, defaults and configuration check for the convolution sequencer.
package fp_conv_pkg;

  localparam int AW_DEF  = 12;
  localparam int DW_DEF  = 6;
  localparam int LAT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLR   = 3'd2,
    FEED  = 3'd3,
    DRAIN = 3'd4,
    EMIT  = 3'd5,
    NEXT  = 3'd6,
    FIN   = 3'd7
  } seq_state_e;

  function automatic logic cfg_illegal(input int unsigned n, input int unsigned m,
                                       input int unsigned s, input int unsigned np);
    return (m == 32'd0) || (s == 32'd0) || (n == 32'd0) || (m > np);
  endfunction

endpackage

// File: rtl/fp_conv_sequencer_if.sv
// Operand bus to the MAC/operand memories plus the result valid/ready handshake.
interface fp_conv_sequencer_if
  import fp_conv_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic [AW-1:0] img_addr;
  logic [AW-1:0] ker_addr;
  logic          op_valid;
  logic          op_pad;
  logic          mac_clr;
  logic          res_valid;
  logic [AW-1:0] res_addr;
  logic          res_ready;

  modport master (
    output img_addr, ker_addr, op_valid, op_pad, mac_clr, res_valid, res_addr,
    input  res_ready
  );

  modport slave (
    input  img_addr, ker_addr, op_valid, op_pad, mac_clr, res_valid, res_addr,
    output res_ready
  );
endinterface

// File: rtl/conv_win_counter.sv
// Nested kernel counter (i outer, j inner) over an M x M window; exposes next values
// so the sequencer can register its addresses one cycle ahead.
module conv_win_counter #(
  parameter int DW = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          step,
  input  logic [DW-1:0] m,
  output logic [DW-1:0] i_nxt,
  output logic [DW-1:0] j_nxt,
  output logic          last
);
  logic [DW-1:0] i_r;
  logic [DW-1:0] j_r;
  logic          last_j_s;

  always_comb begin
    last_j_s = (j_r == m - DW'(1));
    last     = last_j_s && (i_r == m - DW'(1));
    i_nxt    = i_r;
    j_nxt    = j_r;
    if (clr) begin
      i_nxt = '0;
      j_nxt = '0;
    end else if (step) begin
      if (last_j_s) begin
        j_nxt = '0;
        i_nxt = last ? '0 : i_r + DW'(1);
      end else begin
        j_nxt = j_r + DW'(1);
        i_nxt = i_r;
      end
    end else begin
      i_nxt = i_r;
      j_nxt = j_r;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_r <= '0;
      j_r <= '0;
    end else begin
      i_r <= i_nxt;
      j_r <= j_nxt;
    end
  end
endmodule

// File: rtl/fp_conv_sequencer.sv
// Convolution window sequencer for the shared FP MAC.
// Zero padding is built only when FP_CONV_SEQ_PAD_EN is defined; otherwise cfg_p is ignored.
module fp_conv_sequencer
  import fp_conv_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [DW-1:0]              cfg_n,
  input  logic [DW-1:0]              cfg_m,
  input  logic [DW-1:0]              cfg_s,
  input  logic [DW-1:0]              cfg_p,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  fp_conv_sequencer_if.master        bus
);
  localparam int XW = DW + 2;

  seq_state_e    state_r, state_nxt_s;
  logic [DW-1:0] n_r, m_r, s_r;
  logic [DW:0]   p_eff_s, np_s;
  logic [DW:0]   r0_r, c0_r, r0_nxt_s, c0_nxt_s;
  logic [AW-1:0] oidx_r, oidx_nxt_s;
  logic [7:0]    dcnt_r, dcnt_nxt_s;
  logic          err_r, err_nxt_s;
  logic          cnt_clr_s, cnt_step_s, cnt_last_s;
  logic [DW-1:0] i_nxt_s, j_nxt_s;
  logic [XW-1:0] c0_sum_s, r0_sum_s;
  logic [DW:0]   row_s, col_s;
  logic          pad_s, feed_nxt_s;
  logic [AW-1:0] img_s, ker_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_r <= '0;
      m_r <= '0;
      s_r <= '0;
    end else if (state_r == IDLE && start) begin
      n_r <= cfg_n;
      m_r <= cfg_m;
      s_r <= cfg_s;
    end else begin
      n_r <= n_r;
      m_r <= m_r;
      s_r <= s_r;
    end
  end

`ifdef FP_CONV_SEQ_PAD_EN
  logic [DW-1:0] p_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_r <= '0;
    end else if (state_r == IDLE && start) begin
      p_r <= cfg_p;
    end else begin
      p_r <= p_r;
    end
  end
  assign p_eff_s = {1'b0, p_r};
`else
  logic unused_cfg_p_s;
  assign unused_cfg_p_s = ^cfg_p;
  assign p_eff_s        = '0;
`endif

  assign np_s     = {1'b0, n_r} + {p_eff_s[DW-1:0], 1'b0};
  assign c0_sum_s = XW'(c0_r) + XW'(s_r) + XW'(m_r);
  assign r0_sum_s = XW'(r0_r) + XW'(s_r) + XW'(m_r);

  conv_win_counter #(.DW(DW)) u_win (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (cnt_clr_s),
    .step  (cnt_step_s),
    .m     (m_r),
    .i_nxt (i_nxt_s),
    .j_nxt (j_nxt_s),
    .last  (cnt_last_s)
  );

  always_comb begin
    state_nxt_s = state_r;
    r0_nxt_s    = r0_r;
    c0_nxt_s    = c0_r;
    oidx_nxt_s  = oidx_r;
    dcnt_nxt_s  = dcnt_r;
    err_nxt_s   = err_r;
    cnt_clr_s   = 1'b0;
    cnt_step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        r0_nxt_s   = '0;
        c0_nxt_s   = '0;
        oidx_nxt_s = '0;
        cnt_clr_s  = 1'b1;
        if (cfg_illegal(32'(n_r), 32'(m_r), 32'(s_r), 32'(np_s))) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = FIN;
        end else begin
          err_nxt_s   = 1'b0;
          state_nxt_s = CLR;
        end
      end
      CLR: state_nxt_s = FEED;
      FEED: begin
        cnt_step_s = 1'b1;
        if (cnt_last_s) begin
          dcnt_nxt_s  = '0;
          state_nxt_s = (LAT == 0) ? EMIT : DRAIN;
        end else begin
          state_nxt_s = FEED;
        end
      end
      DRAIN: begin
        if (dcnt_r == 8'(LAT - 1)) begin
          state_nxt_s = EMIT;
        end else begin
          dcnt_nxt_s = dcnt_r + 8'd1;
        end
      end
      EMIT: begin
        if (bus.res_ready) begin
          state_nxt_s = NEXT;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      NEXT: begin
        oidx_nxt_s = oidx_r + AW'(1);
        cnt_clr_s  = 1'b1;
        if (c0_sum_s <= XW'(np_s)) begin
          c0_nxt_s    = c0_r + {1'b0, s_r};
          state_nxt_s = CLR;
        end else if (r0_sum_s <= XW'(np_s)) begin
          c0_nxt_s    = '0;
          r0_nxt_s    = r0_r + {1'b0, s_r};
          state_nxt_s = CLR;
        end else begin
          state_nxt_s = FIN;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Addresses are formed from next-cycle origin/counter values so they can be registered.
  always_comb begin
    row_s = r0_nxt_s + {1'b0, i_nxt_s};
    col_s = c0_nxt_s + {1'b0, j_nxt_s};
    ker_s = AW'(i_nxt_s) * AW'(m_r) + AW'(j_nxt_s);
`ifdef FP_CONV_SEQ_PAD_EN
    pad_s = (row_s < p_eff_s) || (row_s >= p_eff_s + {1'b0, n_r}) ||
            (col_s < p_eff_s) || (col_s >= p_eff_s + {1'b0, n_r});
    img_s = AW'(row_s - p_eff_s) * AW'(n_r) + AW'(col_s - p_eff_s);
`else
    pad_s = 1'b0;
    img_s = AW'(row_s) * AW'(n_r) + AW'(col_s);
`endif
  end

  assign feed_nxt_s = (state_nxt_s == FEED);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      r0_r    <= '0;
      c0_r    <= '0;
      oidx_r  <= '0;
      dcnt_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      r0_r    <= r0_nxt_s;
      c0_r    <= c0_nxt_s;
      oidx_r  <= oidx_nxt_s;
      dcnt_r  <= dcnt_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      bus.op_valid  <= 1'b0;
      bus.op_pad    <= 1'b0;
      bus.img_addr  <= '0;
      bus.ker_addr  <= '0;
      bus.mac_clr   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_addr  <= '0;
    end else begin
      busy          <= (state_nxt_s != IDLE);
      done          <= (state_nxt_s == FIN);
      cfg_err       <= (state_nxt_s == FIN) && err_nxt_s;
      bus.op_valid  <= feed_nxt_s;
      bus.op_pad    <= feed_nxt_s && pad_s;
      bus.img_addr  <= (feed_nxt_s && !pad_s) ? img_s : '0;
      bus.ker_addr  <= feed_nxt_s ? ker_s : '0;
      bus.mac_clr   <= (state_nxt_s == CLR);
      bus.res_valid <= (state_nxt_s == EMIT);
      bus.res_addr  <= (state_nxt_s == EMIT) ? oidx_nxt_s : '0;
    end
  end
endmodule

// File: tb/tb_fp_conv_sequencer.sv
// Randomized bench for fp_conv_sequencer against a window-enumeration reference model.
module tb_fp_conv_sequencer;
  localparam int AW  = 12;
  localparam int DW  = 6;
  localparam int LAT = 2;
`ifdef FP_CONV_SEQ_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_n = '0, cfg_m = '0, cfg_s = '0, cfg_p = '0;
  logic          busy, done, cfg_err;

  fp_conv_sequencer_if #(.AW(AW)) bus ();

  fp_conv_sequencer #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_s(cfg_s), .cfg_p(cfg_p),
    .busy(busy), .done(done), .cfg_err(cfg_err), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int exp_ops[$];
  int exp_res[$];
  int exp_nops, exp_nwin, exp_cycles;
  bit exp_err;

  // Enumerate every window origin and kernel tap directly from the geometry.
  task automatic ref_build(input int n, input int m, input int s, input int p);
    int pe, np, row, col, img;
    bit pad;
    pe = PAD_EN ? p : 0;
    np = n + 2 * pe;
    exp_ops.delete();
    exp_res.delete();
    exp_err  = (m == 0) || (s == 0) || (n == 0) || (m > np);
    exp_nwin = 0;
    if (!exp_err) begin
      for (int r0 = 0; r0 + m <= np; r0 += s) begin
        for (int c0 = 0; c0 + m <= np; c0 += s) begin
          for (int i = 0; i < m; i++) begin
            for (int j = 0; j < m; j++) begin
              row = r0 + i;
              col = c0 + j;
              pad = (row < pe) || (row >= pe + n) || (col < pe) || (col >= pe + n);
              img = pad ? 0 : (row - pe) * n + (col - pe);
              exp_ops.push_back(((pad ? 1 : 0) << 24) | (img << 12) | (i * m + j));
            end
          end
          exp_res.push_back(exp_nwin);
          exp_nwin++;
        end
      end
    end
    exp_nops   = exp_ops.size();
    exp_cycles = 2 + exp_nwin * (m * m + LAT + 3);
  endtask

  // bp: 0 always ready, 1 random ready, 2 ready low for the first 5 EMIT cycles.
  task automatic run_job(input int n, input int m, input int s, input int p,
                         input int bp, input bit fin_start, output int done_cyc);
    int cyc, stalls, nops, nclr, nres, hold_cnt, e;
    bit got_done, prev_stall, rdy;
    ref_build(n, m, s, p);
    @(negedge CLK);
    cfg_n = DW'(n); cfg_m = DW'(m); cfg_s = DW'(s); cfg_p = DW'(p);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1; stalls = 0; nops = 0; nclr = 0; nres = 0; hold_cnt = 0;
    got_done = 1'b0; prev_stall = 1'b0; done_cyc = -1;
    while (!got_done && cyc < 6000) begin
      chk_eq("busy", busy, 1);
      if (prev_stall) begin
        e = (exp_res.size() > 0) ? exp_res[0] : -1;
        chk_eq("stall_hold", {bus.res_valid, bus.res_addr}, {1'b1, AW'(e)});
      end
      if (bus.res_valid) chk_eq("emit_quiet", {bus.op_valid, bus.mac_clr}, 0);
      if (bus.mac_clr) nclr++;
      if (bus.op_valid) begin
        e = (exp_ops.size() > 0) ? exp_ops.pop_front() : -1;
        chk_eq("operand", {bus.op_pad, bus.img_addr, bus.ker_addr}, e);
        nops++;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk_eq("done_cycle", cyc, exp_cycles + stalls);
        chk_eq("cfg_err", cfg_err, exp_err);
        chk_eq("op_count", nops, exp_nops);
        chk_eq("clr_count", nclr, exp_nwin);
        chk_eq("res_count", nres, exp_nwin);
      end
      rdy = 1'b1;
      if (bp == 1) rdy = ($urandom_range(0, 2) != 0);
      else if (bp == 2 && bus.res_valid && hold_cnt < 5) begin
        rdy = 1'b0;
        hold_cnt++;
      end
      bus.res_ready = rdy;
      prev_stall = bus.res_valid && !rdy;
      if (prev_stall) stalls++;
      if (bus.res_valid && rdy) begin
        e = (exp_res.size() > 0) ? exp_res.pop_front() : -1;
        chk_eq("res_addr", bus.res_addr, e);
        nres++;
      end
      start = got_done ? fin_start : 1'($urandom_range(0, 1));
      @(negedge CLK);
      cyc++;
    end
    if (!got_done) chk_eq("done_timeout", 0, 1);
    start = 1'b0;
    bus.res_ready = 1'b1;
    chk_eq("after_fin", {busy, done, cfg_err}, 0);
    @(negedge CLK);
    chk_eq("idle_hold", {busy, done}, 0);
  endtask

  initial begin
    int dc, seen, k, dn;
    bus.res_ready = 1'b1;
    #1 RST = 1'b1;
    #10;
    chk_eq("reset_outputs", {busy, done, cfg_err, bus.op_valid, bus.op_pad, bus.mac_clr,
           bus.res_valid, bus.img_addr, bus.ker_addr, bus.res_addr}, 0);
    @(negedge CLK);
    RST = 1'b0;

    run_job(4, 3, 1, 0, 0, 1'b0, dc);
    chk_eq("done_at_58", dc, 58);
    run_job(2, 3, 1, 1, 0, 1'b1, dc);
    run_job(5, 3, 2, 0, 0, 1'b0, dc);
    run_job(4, 3, 1, 0, 2, 1'b0, dc);
    run_job(2, 4, 1, 0, 0, 1'b1, dc);
    chk_eq("illegal_done_at_2", dc, 2);

    // Abort a job mid-FEED with an asynchronous reset.
    @(negedge CLK);
    cfg_n = 6'd4; cfg_m = 6'd3; cfg_s = 6'd1; cfg_p = 6'd0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    seen = 0; k = 0;
    while (seen < 3 && k < 40) begin
      @(negedge CLK);
      k++;
      if (bus.op_valid) seen++;
    end
    chk_eq("rst_reach_feed", seen, 3);
    #2 RST = 1'b1;
    #1;
    chk_eq("rst_outputs", {busy, done, cfg_err, bus.op_valid, bus.op_pad, bus.mac_clr,
           bus.res_valid, bus.img_addr, bus.ker_addr, bus.res_addr}, 0);
    @(negedge CLK);
    RST = 1'b0;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (done || busy) dn++;
    end
    chk_eq("rst_no_done", dn, 0);
    run_job(4, 3, 1, 0, 0, 1'b0, dc);
    chk_eq("post_rst_done_at_58", dc, 58);

    for (int t = 0; t < 24; t++) begin
      run_job($urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 1), 1'($urandom_range(0, 1)), dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
